// File: rtl/inen_oen_regbank_if.sv
// -----------------------------------------------------------------------------
// inen_oen_regbank_if
//   Bus bundle for the inen_oen_regbank scratch register bank.
//   master : drives write/read/clear requests, observes read data and status.
//   slave  : the register bank itself.
//   Signals:
//     data_in    [WIDTH]  write data
//     inen                write enable (entry waddr)
//     waddr      [AW]     write address
//     oen                 read/output enable (entry raddr)
//     raddr      [AW]     read address
//     sclr                synchronous clear of the whole bank
//     data_out   [WIDTH]  registered read data (0 when output disabled)
//     out_valid           data_out was produced by a read
//     rd_hit              the entry read held valid data
//     wr_err              one-cycle pulse after an out-of-range write
//     used_count [AW+1]   number of valid entries
//     full / empty        used_count == DEPTH / used_count == 0
// -----------------------------------------------------------------------------
interface inen_oen_regbank_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic [WIDTH-1:0] data_in;
    logic             inen;
    logic [AW-1:0]    waddr;
    logic             oen;
    logic [AW-1:0]    raddr;
    logic             sclr;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             rd_hit;
    logic             wr_err;
    logic [AW:0]      used_count;
    logic             full;
    logic             empty;

    modport master (
        output data_in, inen, waddr, oen, raddr, sclr,
        input  data_out, out_valid, rd_hit, wr_err, used_count, full, empty
    );

    modport slave (
        input  data_in, inen, waddr, oen, raddr, sclr,
        output data_out, out_valid, rd_hit, wr_err, used_count, full, empty
    );
endinterface

// File: rtl/inen_oen_regbank.sv
// -----------------------------------------------------------------------------
// inen_oen_regbank
//   DEPTH independently addressed WIDTH-bit registers, each with a valid flag.
//   One write port (inen/waddr/data_in), one registered read port
//   (oen/raddr -> data_out one cycle later), synchronous whole-bank clear,
//   occupancy counter with full/empty flags and an out-of-range write error.
//   Ports:
//     clk  : clock, all state updates on the rising edge
//     clr  : asynchronous active-high reset, overrides everything
//     bus  : inen_oen_regbank_if.slave (see interface file for signals)
//   Parameters:
//     WIDTH  : data width of each register
//     DEPTH  : number of registers (2..16), DEPTH <= 2**AW
//     AW     : address width
//     BYPASS : 1 -> a read colliding with a write returns data_in;
//              0 -> it returns the previous contents
// -----------------------------------------------------------------------------
module inen_oen_regbank #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   clr,
    inen_oen_regbank_if.slave      bus
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             out_valid_q, out_valid_d;
    logic             rd_hit_q, rd_hit_d;
    logic             wr_err_q, wr_err_d;
    logic [AW:0]      used_count_q, used_count_d;

    logic             wr_in_range;
    logic             collide;

    assign wr_in_range = ({1'b0, bus.waddr} < DEPTH_W);
    // Bypass only applies to a write that will actually land; sclr drops it.
    assign collide     = (BYPASS != 0) && bus.inen && !bus.sclr
                         && (bus.waddr == bus.raddr);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        mem_d        = mem_q;
        valid_d      = valid_q;
        used_count_d = used_count_q;
        wr_err_d     = 1'b0;
        data_out_d   = '0;
        out_valid_d  = 1'b0;
        rd_hit_d     = 1'b0;

        // Read port: samples pre-edge contents; out-of-range or disabled
        // reads leave data_out at zero so no stale data is ever visible.
        if (bus.oen) begin
            out_valid_d = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.raddr == AW'(i)) begin
                    if (collide) begin
                        data_out_d = bus.data_in;
                        rd_hit_d   = 1'b1;
                    end else begin
                        data_out_d = mem_q[i];
                        rd_hit_d   = valid_q[i];
                    end
                end
            end
        end

        // Write port: sclr wins over a write and suppresses its error.
        if (bus.sclr) begin
            mem_d        = '{default: '0};
            valid_d      = '0;
            used_count_d = '0;
        end else if (bus.inen) begin
            wr_err_d = !wr_in_range;
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.waddr == AW'(i)) begin
                    mem_d[i]   = bus.data_in;
                    valid_d[i] = 1'b1;
                    // Only an invalid->valid transition counts, so the
                    // counter can never exceed DEPTH.
                    if (!valid_q[i]) begin
                        used_count_d = used_count_q + (AW+1)'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            // NOTE: the storage array is reset too, because a cleared bank must read back as zeros.
            mem_q        <= '{default: '0};
            valid_q      <= '0;
            data_out_q   <= '0;
            out_valid_q  <= 1'b0;
            rd_hit_q     <= 1'b0;
            wr_err_q     <= 1'b0;
            used_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values.
            mem_q        <= mem_d;
            valid_q      <= valid_d;
            data_out_q   <= data_out_d;
            out_valid_q  <= out_valid_d;
            rd_hit_q     <= rd_hit_d;
            wr_err_q     <= wr_err_d;
            used_count_q <= used_count_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.rd_hit     = rd_hit_q;
    assign bus.wr_err     = wr_err_q;
    assign bus.used_count = used_count_q;
    assign bus.full       = (used_count_q == DEPTH_W);
    assign bus.empty      = (used_count_q == '0);

endmodule
